grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Parametrised general register file for the MIPS core: 2**ADDR_W registers of DATA_W bits, NUM_READ combinational read ports and one synchronous write port.
- Adds a per-register busy scoreboard so the decode stage can detect RAW hazards on in-flight results.
- Replaces the fixed 32x32, 2-read GRF between decode (reads, allocation) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_READ, 2, number of read ports (1..4)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- writeEnable  in  1  commit writeData to writeReg at next rising edge
- writeReg  in  ADDR_W  write index
- writeData  in  DATA_W  write value
- PCReg  in  32  PC of the writing instruction; used only by the optional feature
- allocEnable  in  1  mark allocReg busy (producer issued)
- allocReg  in  ADDR_W  index to mark busy
- readRegs  in  NUM_READ*ADDR_W  packed read indices; port i uses bits [i*ADDR_W +: ADDR_W]
- readData  out  NUM_READ*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
- readBusy  out  NUM_READ  bit i = register addressed by port i is busy
- busyCount  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: while reset=0, asynchronously clear all registers to 0 and all busy bits to 0. busyCount=0, readData=0, readBusy=0. Reset is level-sensitive; any in-flight write or alloc in the deassertion cycle is dropped.
- Register 0:
  - Always reads 0 and is never busy.
  - writeEnable or allocEnable targeting index 0 has no effect, and busyCount does not change.
- Write: at posedge with writeEnable=1 and writeReg!=0, load writeData into the register and clear its busy bit.
- Alloc: at posedge with allocEnable=1 and allocReg!=0, set its busy bit. Allocating an already-busy register leaves it busy; busyCount does not change.
- Same edge, same register, write and alloc: alloc wins. Data is written and the busy bit ends at 1 (back-to-back producers).
- Same edge, different registers: both take effect independently.
- Read: combinational, zero latency, from stored state. A same-cycle write is not visible until after the edge unless the optional feature is enabled.
- readBusy reflects stored busy bits only; the same-cycle alloc/write effect appears after the edge.
- busyCount: registered count that always equals the popcount of the busy vector.
  - Update per edge by +1 (new alloc of a non-busy register), -1 (write clearing a busy register, not re-allocated), or 0.
  - Never exceeds 2**ADDR_W-1.
- A write to a non-busy register is legal: data is stored, busy stays 0, count unchanged.

Optional Feature:
- Macro GRF_BYPASS_EN.
- Defined:
  - Each read port whose index equals writeReg while writeEnable=1 and writeReg!=0 returns writeData in the same cycle.
  - readBusy for that port is 0, unless allocEnable targets the same register in that cycle, in which case readBusy=1.
- Undefined: reads return stored values only, as described under Behaviour.

Decomposition:
- Shared package grf_pkg:
  - default width constants (DATA_W_DEF=32, ADDR_W_DEF=5)
  - ZERO_REG=0 constant
  - helper function for packed-port slicing
- One natural sub-module, grf_busy_tracker: busy vector, alloc/clear priority and busyCount.
- The data array and read muxes stay in the top.

Test Plan:
- Reset: write reg 10 = 0x10, pulse reset low mid-cycle -> readData of reg 10 = 0 immediately, busyCount = 0, readBusy = 0.
- Zero register: writeEnable, writeReg=0, writeData=3, plus allocReg=0 -> reads of reg 0 return 0, readBusy=0, busyCount stays 0.
- Scoreboard: alloc reg 5, then reg 7 -> busyCount = 2, readBusy=1 on port reading 5. Write reg 5 = 0x12345678 -> port reads 0x12345678, readBusy=0, busyCount = 1.
- Collision: same edge alloc reg 9 and write reg 9 = 0xFFFFFFFF -> reg 9 reads 0xFFFFFFFF and stays busy, busyCount +1 (not previously busy).
- Read timing, with NUM_READ=3 and all ports reading reg 4 while it is written with 0xA5A5A5A5:
  - without GRF_BYPASS_EN: old value during the cycle, 0xA5A5A5A5 after the edge.
  - with GRF_BYPASS_EN: 0xA5A5A5A5 in the same cycle.
- Saturation (ADDR_W=2): alloc regs 1,2,3 -> busyCount = 3. Re-alloc reg 3 -> busyCount stays 3. Write all three -> busyCount = 0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants, counter-step encoding and packed-port helper for the GRF scoreboard.
package grf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cntStep_e;

  // LSB position of port `port` inside a packed bus of `width`-bit fields.
  function automatic int unsigned portLsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/grf_busy_tracker.sv
// Per-register busy scoreboard: alloc sets, write clears (alloc wins on collision),
// with a registered population count.
module grf_busy_tracker
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     writeEnable,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic                     allocEnable,
  input  logic [ADDR_W-1:0]        allocReg,
  output logic [(1<<ADDR_W)-1:0]   busyVec,
  output logic [ADDR_W:0]          busyCount
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic             writeHit;
  logic             allocHit;
  logic             cntInc;
  logic             cntDec;
  logic [DEPTH-1:0] busyNext;
  cntStep_e         step;

  always_comb begin
    writeHit = writeEnable && (writeReg != ADDR_W'(ZERO_REG));
    allocHit = allocEnable && (allocReg != ADDR_W'(ZERO_REG));

    busyNext = busyVec;
    if (writeHit) busyNext[writeReg] = 1'b0;
    if (allocHit) busyNext[allocReg] = 1'b1;

    // A write only retires a busy bit if the same edge does not re-allocate it.
    cntInc = allocHit && !busyVec[allocReg];
    cntDec = writeHit && busyVec[writeReg] && !(allocHit && (allocReg == writeReg));

    step = CNT_HOLD;
    unique case ({cntInc, cntDec})
      2'b10:   step = CNT_INC;
      2'b01:   step = CNT_DEC;
      default: step = CNT_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyVec   <= '0;
      busyCount <= '0;
    end else begin
      busyVec <= busyNext;
      unique case (step)
        CNT_INC: busyCount <= busyCount + (ADDR_W+1)'(1);
        CNT_DEC: busyCount <= busyCount - (ADDR_W+1)'(1);
        default: busyCount <= busyCount;
      endcase
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with combinational read ports and a busy scoreboard.
// Optional same-cycle write-to-read bypass: define GRF_BYPASS_EN.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_READ = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         writeEnable,
  input  logic [ADDR_W-1:0]            writeReg,
  input  logic [DATA_W-1:0]            writeData,
  input  logic [31:0]                  PCReg,
  input  logic                         allocEnable,
  input  logic [ADDR_W-1:0]            allocReg,
  input  logic [NUM_READ*ADDR_W-1:0]   readRegs,
  output logic [NUM_READ*DATA_W-1:0]   readData,
  output logic [NUM_READ-1:0]          readBusy,
  output logic [ADDR_W:0]              busyCount
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DEPTH-1:0]  busyVec;
  logic [ADDR_W-1:0] rdIdx;
  logic              writeHit;
  logic              unusedPc;

  assign unusedPc = ^PCReg;
  assign writeHit = writeEnable && (writeReg != ADDR_W'(ZERO_REG));

  grf_busy_tracker #(
    .ADDR_W (ADDR_W)
  ) uBusy (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .allocEnable (allocEnable),
    .allocReg    (allocReg),
    .busyVec     (busyVec),
    .busyCount   (busyCount)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regFile[i] <= '0;
    end else if (writeHit) begin
      regFile[writeReg] <= writeData;
    end
  end

  always_comb begin
    readData = '0;
    readBusy = '0;
    rdIdx    = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rdIdx = readRegs[portLsb(i, ADDR_W) +: ADDR_W];
      readData[portLsb(i, DATA_W) +: DATA_W] =
        (rdIdx == ADDR_W'(ZERO_REG)) ? '0 : regFile[rdIdx];
      readBusy[i] = busyVec[rdIdx];
`ifdef GRF_BYPASS_EN
      // Forwarded data is gated by reset so outputs stay zero while it is held.
      if (reset && writeHit && (rdIdx == writeReg)) begin
        readData[portLsb(i, DATA_W) +: DATA_W] = writeData;
        readBusy[i] = allocEnable && (allocReg == writeReg);
      end
`endif
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised scoreboard bench for grf_scoreboard (main 32x32/3-port instance
// plus a 4-entry instance for count saturation).
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0, ae = 1'b0;
  logic [4:0]  wr = '0, ar = '0;
  logic [31:0] wd = '0, pc = '0;
  logic [14:0] rr = '0;
  logic [95:0] rd;
  logic [2:0]  rb;
  logic [5:0]  bc;

  logic        sWe = 1'b0, sAe = 1'b0;
  logic [1:0]  sWr = '0, sAr = '0, sRr = '0;
  logic [31:0] sWd = '0;
  logic [31:0] sRd;
  logic [0:0]  sRb;
  logic [2:0]  sBc;

  always #5 clk = ~clk;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(3)) dut (
    .clk(clk), .reset(reset), .writeEnable(we), .writeReg(wr), .writeData(wd),
    .PCReg(pc), .allocEnable(ae), .allocReg(ar), .readRegs(rr),
    .readData(rd), .readBusy(rb), .busyCount(bc)
  );

  grf_scoreboard #(.DATA_W(32), .ADDR_W(2), .NUM_READ(1)) dutSmall (
    .clk(clk), .reset(reset), .writeEnable(sWe), .writeReg(sWr), .writeData(sWd),
    .PCReg(pc), .allocEnable(sAe), .allocReg(sAr), .readRegs(sRr),
    .readData(sRd), .readBusy(sRb), .busyCount(sBc)
  );

  typedef struct {
    logic [95:0] data;
    logic [2:0]  busy;
    logic [5:0]  cnt;
    logic [31:0] sData;
    logic        sBusy;
    logic [2:0]  sCnt;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          fails = 0;

  logic [31:0] mMem [32];
  bit          mBusy[32];
  logic [31:0] sMem [4];
  bit          sBusyM[4];

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: samples outputs mid low-phase and compares against queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("readData",   96'(rd),  96'(e.data));
        chk("readBusy",   96'(rb),  96'(e.busy));
        chk("busyCount",  96'(bc),  96'(e.cnt));
        chk("sReadData",  96'(sRd), 96'(e.sData));
        chk("sReadBusy",  96'(sRb), 96'(e.sBusy));
        chk("sBusyCount", 96'(sBc), 96'(e.sCnt));
      end
    end
  end

  function automatic logic [14:0] pack3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  task automatic step(input logic r, input logic w, input logic [4:0] wi, input logic [31:0] wdat,
                      input logic a, input logic [4:0] ai, input logic [14:0] rIdx,
                      input logic sw, input logic [1:0] swi, input logic sa, input logic [1:0] sai,
                      input logic [1:0] sri);
    exp_t        e;
    logic [31:0] sdat;
    logic [4:0]  idx;
    @(negedge clk);
    sdat = $urandom;
    reset = r; we = w; wr = wi; wd = wdat; ae = a; ar = ai; rr = rIdx; pc = $urandom;
    sWe = sw; sWr = swi; sWd = sdat; sAe = sa; sAr = sai; sRr = sri;
    if (!r) begin
      foreach (mMem[k]) begin mMem[k] = '0; mBusy[k] = 0; end
      foreach (sMem[k]) begin sMem[k] = '0; sBusyM[k] = 0; end
    end
    e.data = '0; e.busy = '0; e.cnt = '0;
    for (int p = 0; p < 3; p++) begin
      idx = rIdx[p*5 +: 5];
      e.data[p*32 +: 32] = (idx == 0) ? 32'd0 : mMem[idx];
      e.busy[p] = mBusy[idx];
`ifdef GRF_BYPASS_EN
      if (r && w && wi != 0 && idx == wi) begin
        e.data[p*32 +: 32] = wdat;
        e.busy[p] = a && (ai == wi);
      end
`endif
    end
    foreach (mBusy[k]) if (mBusy[k]) e.cnt = e.cnt + 6'd1;
    e.sData = (sri == 0) ? 32'd0 : sMem[sri];
    e.sBusy = sBusyM[sri];
`ifdef GRF_BYPASS_EN
    if (r && sw && swi != 0 && sri == swi) begin
      e.sData = sdat;
      e.sBusy = sa && (sai == swi);
    end
`endif
    e.sCnt = '0;
    foreach (sBusyM[k]) if (sBusyM[k]) e.sCnt = e.sCnt + 3'd1;
    expQ.push_back(e);
    @(posedge clk);
    if (r) begin
      if (w && wi != 0) begin mMem[wi] = wdat; mBusy[wi] = 0; end
      if (a && ai != 0) mBusy[ai] = 1;
      if (sw && swi != 0) begin sMem[swi] = sdat; sBusyM[swi] = 0; end
      if (sa && sai != 0) sBusyM[sai] = 1;
    end
  endtask

  task automatic mainOp(input logic r, input logic w, input logic [4:0] wi, input logic [31:0] wdat,
                        input logic a, input logic [4:0] ai, input logic [14:0] rIdx);
    step(r, w, wi, wdat, a, ai, rIdx, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic smallOp(input logic sw, input logic [1:0] swi, input logic sa,
                         input logic [1:0] sai, input logic [1:0] sri);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 15'd0, sw, swi, sa, sai, sri);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wi, ai, r0, r1, r2;
    foreach (mMem[k]) begin mMem[k] = '0; mBusy[k] = 0; end
    foreach (sMem[k]) begin sMem[k] = '0; sBusyM[k] = 0; end

    // Reset state, then async reset pulse wiping a written register
    mainOp(0, 0, 0, 0, 0, 0, pack3(10, 0, 0));
    mainOp(1, 0, 0, 0, 0, 0, pack3(10, 0, 0));
    mainOp(1, 1, 10, 32'h10, 0, 0, pack3(10, 10, 10));
    mainOp(1, 0, 0, 0, 0, 0, pack3(10, 10, 10));
    mainOp(0, 0, 0, 0, 0, 0, pack3(10, 10, 10));
    mainOp(1, 0, 0, 0, 0, 0, pack3(10, 10, 10));

    // Register 0 ignores writes and allocs
    mainOp(1, 1, 0, 32'd3, 1, 0, pack3(0, 0, 0));
    mainOp(1, 0, 0, 0, 0, 0, pack3(0, 0, 0));

    // Scoreboard alloc/clear
    mainOp(1, 0, 0, 0, 1, 5, pack3(5, 7, 0));
    mainOp(1, 0, 0, 0, 1, 7, pack3(5, 7, 0));
    mainOp(1, 0, 0, 0, 0, 0, pack3(5, 7, 0));
    mainOp(1, 1, 5, 32'h12345678, 0, 0, pack3(5, 7, 0));
    mainOp(1, 0, 0, 0, 0, 0, pack3(5, 7, 0));

    // Same-edge write and alloc on one register
    mainOp(1, 1, 9, 32'hFFFFFFFF, 1, 9, pack3(9, 9, 9));
    mainOp(1, 0, 0, 0, 0, 0, pack3(9, 9, 9));

    // Read timing around a write of reg 4, plus write+alloc visibility
    mainOp(1, 1, 4, 32'h11, 0, 0, pack3(4, 4, 4));
    mainOp(1, 1, 4, 32'hA5A5A5A5, 0, 0, pack3(4, 4, 4));
    mainOp(1, 0, 0, 0, 0, 0, pack3(4, 4, 4));
    mainOp(1, 1, 4, 32'h5A5A5A5A, 1, 4, pack3(4, 4, 4));
    mainOp(1, 0, 0, 0, 0, 0, pack3(4, 4, 4));

    // Saturation on the 4-entry instance
    smallOp(0, 0, 1, 1, 1);
    smallOp(0, 0, 1, 2, 2);
    smallOp(0, 0, 1, 3, 3);
    smallOp(0, 0, 1, 3, 3);
    smallOp(0, 0, 0, 0, 3);
    smallOp(1, 1, 0, 0, 1);
    smallOp(1, 2, 0, 0, 2);
    smallOp(1, 3, 0, 0, 3);
    smallOp(0, 0, 0, 0, 3);

    // Randomised traffic, biased toward low indices to provoke collisions
    for (int n = 0; n < 400; n++) begin
      wi = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ai = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 1) != 0) ? wi : 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), wi, $urandom,
           1'($urandom_range(0, 1)), ai, pack3(r0, r1, r2),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    mainOp(1, 0, 0, 0, 0, 0, pack3(1, 2, 3));
    repeat (3) @(negedge clk);
    #5;
    if (expQ.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending predictions expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
